blfh_cipher_packer: RTL

- Upstream feeder for the Blowfish decrypt stage.
- Takes a byte stream from the serial/host link and assembles the 32-bit secret key and 64-bit ciphertext blocks, most-significant byte first.
- Buffers completed blocks in a small FIFO and presents them on a valid/ready interface.
- Holds the key stable on `key` while ciphertext blocks are delivered as `dec_ciphertext`.

---
 rtl/blfh_cipher_packer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/blfh_cipher_packer.sv
`default_nettype none
// ============================================================================
//  Module   : blfh_cipher_packer
//  Purpose  : Byte-stream front end for the Blowfish decrypt stage. Collects
//             a 32-bit key and 64-bit ciphertext blocks (MSB byte first),
//             queues finished blocks in a small FIFO and presents them on a
//             valid/ready interface while holding the key stable.
//  Revision : 1.0  initial release
// ============================================================================
module blfh_cipher_packer #(
    parameter int FIFO_DEPTH = 2,
    parameter int KEY_BYTES  = 4,
    parameter int BLK_BYTES  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_load,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] key,
    output logic        key_valid,
    output logic [63:0] dec_ciphertext,
    output logic        blk_valid,
    input  logic        blk_ready,
    output logic [15:0] blk_count,
    output logic        overflow
);

    localparam int         AW          = $clog2(FIFO_DEPTH);
    localparam int         PW          = AW + 1;
    localparam logic [2:0] c_KEY_LAST  = 3'(KEY_BYTES - 1);
    localparam logic [2:0] c_BLK_LAST  = 3'(BLK_BYTES - 1);

    typedef enum logic [1:0] {
        ST_WAIT_KEY = 2'd0,
        ST_LOAD_KEY = 2'd1,
        ST_DATA     = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [2:0]    r_cnt;
    logic [63:0]   r_shift;
    logic [31:0]   r_key;
    logic          r_key_valid;

    logic [63:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] w_rd_next;
    logic [63:0]   r_head;
    logic [15:0]   r_blk_count;
    logic          r_overflow;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_key_done;
    logic          w_push;
    logic          w_wr_en;
    logic [63:0]   w_push_data;

    // FIFO occupancy flags from the extra wrap bit of each pointer
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = !w_empty && blk_ready;
    assign w_rd_next = r_rd_ptr + 1'b1;

    // A key_load pulse always wins over a byte presented in the same cycle
    assign w_accept    = in_valid && w_in_ready && !key_load;
    assign w_key_done  = w_accept && (r_state == ST_LOAD_KEY) && (r_cnt == c_KEY_LAST);
    assign w_push      = w_accept && (r_state == ST_DATA) && (r_cnt == c_BLK_LAST);
    assign w_push_data = {r_shift[55:0], in_byte};
    // A push while full only lands if the head leaves on the same edge
    assign w_wr_en     = w_push && (!w_full || w_pop);

    // Byte acceptance: back-pressure only the completing byte when no slot frees up
    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            ST_LOAD_KEY: w_in_ready = 1'b1;
            ST_DATA:     w_in_ready = !(w_full && (r_cnt == c_BLK_LAST) && !w_pop);
            default:     w_in_ready = 1'b0;
        endcase
    end

    // Next-state selection for the key / data sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT_KEY: begin
                if (key_load) w_state_nxt = ST_LOAD_KEY;
            end
            ST_LOAD_KEY: begin
                if (key_load)        w_state_nxt = ST_LOAD_KEY;
                else if (w_key_done) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (key_load) w_state_nxt = ST_LOAD_KEY;
            end
            default: w_state_nxt = ST_WAIT_KEY;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_WAIT_KEY;
        else        r_state <= w_state_nxt;
    end

    // Byte assembly: shift register, byte counter and key capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_key       <= '0;
            r_key_valid <= 1'b0;
        end else if (key_load) begin
            // Restart counting; any partial block is abandoned
            r_cnt <= '0;
        end else if (w_accept) begin
            r_shift <= w_push_data;
            if (w_key_done || w_push) r_cnt <= '0;
            else                      r_cnt <= r_cnt + 3'd1;
            if (w_key_done) begin
                r_key       <= {r_shift[23:0], in_byte};
                r_key_valid <= 1'b1;
            end
        end
    end

    // FIFO storage and pointers, plus overflow and pop statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_blk_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr[AW-1:0]] <= w_push_data;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr    <= w_rd_next;
                r_blk_count <= r_blk_count + 16'd1;
            end
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    // Output head register: follows the FIFO head, holds last popped block when empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
        end else if (w_pop) begin
            if (w_rd_next != r_wr_ptr) r_head <= r_mem[w_rd_next[AW-1:0]];
            else if (w_wr_en)          r_head <= w_push_data;
        end else if (w_empty && w_wr_en) begin
            r_head <= w_push_data;
        end
    end

    assign in_ready       = w_in_ready;
    assign key            = r_key;
    assign key_valid      = r_key_valid;
    assign dec_ciphertext = r_head;
    assign blk_valid      = !w_empty;
    assign blk_count      = r_blk_count;
    assign overflow       = r_overflow;

endmodule
`default_nettype wire
